pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline controller for the decode stage. Keeps a per-register scoreboard of pending writebacks and stalls decode on RAW/WAW-overflow hazards.
- Sequences flushes on execute-stage redirects and exceptions, and drives the stall/flush inputs of fetch and decode.
- Sits beside decode and sees decoded register addresses and the writeback port.

Parameters:
- PEND_W, 2, width of each per-register pending-write counter; max outstanding writes per register = 2^PEND_W-1.
- FLUSH_CYCLES, 2, number of cycles flush is held after a redirect (1..15).
- WB_BYPASS, 1, if 1 a same-cycle writeback that drops a source counter to 0 suppresses the RAW stall.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets immediately).
- dec_valid  in  1  decode holds a valid, non-excepting instruction.
- dec_rs1_addr  in  5  source 1 address.
- dec_rs1_used  in  1  instruction reads rs1.
- dec_rs2_addr  in  5  source 2 address.
- dec_rs2_used  in  1  instruction reads rs2.
- dec_rd_addr  in  5  destination address.
- dec_rd_used  in  1  instruction writes rd.
- wb_valid  in  1  writeback retiring a register write this cycle.
- wb_rd_addr  in  5  writeback destination.
- ex_redirect  in  1  execute resolved a taken branch/jump (1-cycle pulse).
- ex_excep  in  1  execute raised an exception (1-cycle pulse).
- trap_ack  in  1  trap handler redirect ready; leave TRAP.
- mem_busy  in  1  memory stage cannot accept; freeze front end.
- stall_fetch  out  1  stall to fetch.
- stall_decode  out  1  stall to decode.
- flush_fetch  out  1  flush to fetch.
- flush_decode  out  1  flush to decode.
- issue  out  1  decode instruction advances this cycle.
- busy_vec  out  32  bit i = pending counter of x_i nonzero; bit 0 always 0.
- sb_underflow  out  1  sticky: writeback seen with counter 0.

Behaviour:
- Reset (async, reset==0):
  - All counters 0; state RUN; flush counter 0; last_issue_valid 0.
  - All outputs 0.
- FSM states: RUN, FLUSH, TRAP.
  - RUN->TRAP on ex_excep. ex_excep has priority over a simultaneous ex_redirect.
  - RUN->FLUSH on ex_redirect; flush counter loads FLUSH_CYCLES.
  - FLUSH: counter decrements each cycle; ->RUN when it reaches 1. ex_redirect in FLUSH reloads the counter; ex_excep ->TRAP.
  - TRAP: ->RUN on trap_ack (trap_ack outside TRAP is ignored).
- flush_fetch = flush_decode = 1 when:
  - in FLUSH or TRAP, or
  - in the cycle ex_redirect/ex_excep arrives (combinational).
  - Net effect: flush held for FLUSH_CYCLES+1 cycles on redirect.
- Hazard (combinational):
  - RAW: (rs1_used & rs1!=0 & cnt[rs1]!=0) | (rs2_used & rs2!=0 & cnt[rs2]!=0).
  - With WB_BYPASS, a source is clear if wb_valid & wb_rd_addr==src & cnt[src]==1.
  - WAW-overflow: rd_used & rd!=0 & cnt[rd] == max.
- stall_decode = stall_fetch = dec_valid & (hazard | mem_busy), only in RUN with no flush asserted; otherwise 0, since flush dominates.
- issue = dec_valid & ~stall_decode & ~flush_decode.
- Counter update per cycle:
  - +1 on cnt[rd] if issue & rd_used & rd!=0.
  - -1 on cnt[wb_rd_addr] if wb_valid & wb_rd_addr!=0.
  - -1 undo: on ex_redirect or ex_excep, if last_issue_valid, decrement last_issue_rd. This removes the younger instruction issued the previous cycle, which is being squashed.
  - Updates to the same register sum (e.g. +1-1 = unchanged). The result is clamped to [0, max].
  - Decrement of a zero counter sets sb_underflow (sticky until reset). Undo of a zero counter does not.
- last_issue_valid/last_issue_rd register issue&rd_used&rd!=0 and dec_rd_addr every cycle.
- x0: never counted, never stalls.
- busy_vec is derived from registered counters (no same-cycle visibility).

Test Plan:
- Issue `addi x5` (rd=5), next cycle an instruction reading rs1=5 -> stall_decode=1 until wb_valid with wb_rd_addr=5. With WB_BYPASS=1, issue=1 in that same cycle; busy_vec[5] 1->0.
- Issue 3 writes to x7 with no writeback, then a 4th write to x7 -> 4th stalls (cnt=3=max). A wb to x7 with the 4th still pending -> 4th issues the same cycle, cnt stays 3.
- Issue a write to x9 at t, ex_redirect at t+1 -> cnt[9] returns to 0 at t+2. flush_fetch/flush_decode high t+1..t+3 (FLUSH_CYCLES=2); stall outputs 0 during the flush.
- ex_excep and ex_redirect in the same cycle -> TRAP; flush held until trap_ack. trap_ack pulse -> RUN next cycle, flush deasserts.
- wb_valid to x12 with cnt[12]=0 -> sb_underflow=1 and stays 1. rs1=0 read while wb/issue target x0 -> no stall, busy_vec[0]=0.
- Drive reset low mid-FLUSH with counters nonzero -> immediately all outputs 0, busy_vec=0, state RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard controller: per-register pending-write scoreboard,
// RAW / WAW-overflow stalls, and redirect/exception flush sequencing.
module pipe_hazard_ctrl #(
    parameter int PEND_W       = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter bit WB_BYPASS    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1_addr,
    input  logic        dec_rs1_used,
    input  logic [4:0]  dec_rs2_addr,
    input  logic        dec_rs2_used,
    input  logic [4:0]  dec_rd_addr,
    input  logic        dec_rd_used,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd_addr,
    input  logic        ex_redirect,
    input  logic        ex_excep,
    input  logic        trap_ack,
    input  logic        mem_busy,
    output logic        stall_fetch,
    output logic        stall_decode,
    output logic        flush_fetch,
    output logic        flush_decode,
    output logic        issue,
    output logic [31:0] busy_vec,
    output logic        sb_underflow
);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    typedef enum logic [1:0] {RUN, FLUSH, TRAP} state_t;

    state_t            state;
    logic [3:0]        flush_cnt;
    logic [PEND_W-1:0] cnt      [32];
    logic [PEND_W-1:0] cnt_next [32];
    logic              last_issue_valid;
    logic [4:0]        last_issue_rd;

    logic [PEND_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
    logic              rs1_raw, rs2_raw, waw_full, hazard;
    logic              flush_req, flush, stall;
    logic              issue_wr, wb_dec, undo;
    int                sum;

    assign rs1_cnt = cnt[dec_rs1_addr];
    assign rs2_cnt = cnt[dec_rs2_addr];
    assign rd_cnt  = cnt[dec_rd_addr];

    assign rs1_raw = dec_rs1_used && dec_rs1_addr != 5'd0 && rs1_cnt != '0
                     && !(WB_BYPASS && wb_valid && wb_rd_addr == dec_rs1_addr && rs1_cnt == CNT_ONE);
    assign rs2_raw = dec_rs2_used && dec_rs2_addr != 5'd0 && rs2_cnt != '0
                     && !(WB_BYPASS && wb_valid && wb_rd_addr == dec_rs2_addr && rs2_cnt == CNT_ONE);
    // A same-cycle writeback to rd frees a slot, so a full counter need not block.
    assign waw_full = dec_rd_used && dec_rd_addr != 5'd0 && rd_cnt == CNT_MAX
                      && !(WB_BYPASS && wb_valid && wb_rd_addr == dec_rd_addr);
    assign hazard   = rs1_raw || rs2_raw || waw_full;

    // Outputs are held low for as long as reset is asserted, not only after it.
    assign flush_req = ex_redirect || ex_excep;
    assign flush     = reset && (state != RUN || flush_req);
    assign stall     = reset && !flush && dec_valid && (hazard || mem_busy);
    assign issue     = reset && dec_valid && !stall && !flush;

    assign stall_fetch  = stall;
    assign stall_decode = stall;
    assign flush_fetch  = flush;
    assign flush_decode = flush;

    assign issue_wr = issue && dec_rd_used && dec_rd_addr != 5'd0;
    assign wb_dec   = wb_valid && wb_rd_addr != 5'd0;
    assign undo     = flush_req && last_issue_valid;

    always_comb begin
        // NOTE: every variable written here gets a value on every path, so no latch is inferred.
        sum         = 0;
        cnt_next[0] = '0;
        for (int i = 1; i < 32; i++) begin
            sum = int'(cnt[i]);
            if (issue_wr && dec_rd_addr == 5'(i))   sum = sum + 1;
            if (wb_dec && wb_rd_addr == 5'(i))      sum = sum - 1;
            if (undo && last_issue_rd == 5'(i))     sum = sum - 1;
            if (sum < 0)                            cnt_next[i] = '0;
            else if (sum > int'(CNT_MAX))           cnt_next[i] = CNT_MAX;
            else                                    cnt_next[i] = PEND_W'(sum);
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < 32; i++) busy_vec[i] = (cnt[i] != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the scoreboard is a flop array, not RAM, so it is cleared by reset.
            for (int i = 0; i < 32; i++) cnt[i] <= '0;
            last_issue_valid <= 1'b0;
            last_issue_rd    <= 5'd0;
            sb_underflow     <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) cnt[i] <= cnt_next[i];
            last_issue_valid <= issue_wr;
            last_issue_rd    <= dec_rd_addr;
            if (wb_dec && cnt[wb_rd_addr] == '0) sb_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            flush_cnt <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_excep) begin
                        state <= TRAP;
                    end else if (ex_redirect) begin
                        state     <= FLUSH;
                        flush_cnt <= 4'(FLUSH_CYCLES);
                    end
                end
                FLUSH: begin
                    if (ex_excep) begin
                        state <= TRAP;
                    end else if (ex_redirect) begin
                        flush_cnt <= 4'(FLUSH_CYCLES);
                    end else if (flush_cnt <= 4'd1) begin
                        state     <= RUN;
                        flush_cnt <= 4'd0;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                TRAP: begin
                    if (trap_ack) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed table, corner-case sequences,
// and randomized traffic compared against a scoreboard-level reference model.
module tb_pipe_hazard_ctrl;
    localparam int PEND_W       = 2;
    localparam int FLUSH_CYCLES = 2;
    localparam bit WB_BYPASS    = 1'b1;
    localparam int MAXC         = (1 << PEND_W) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dec_valid, dec_rs1_used, dec_rs2_used, dec_rd_used;
    logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr, wb_rd_addr;
    logic        wb_valid, ex_redirect, ex_excep, trap_ack, mem_busy;
    logic        stall_fetch, stall_decode, flush_fetch, flush_decode, issue, sb_underflow;
    logic [31:0] busy_vec;

    pipe_hazard_ctrl #(.PEND_W(PEND_W), .FLUSH_CYCLES(FLUSH_CYCLES), .WB_BYPASS(WB_BYPASS)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid),
        .dec_rs1_addr(dec_rs1_addr), .dec_rs1_used(dec_rs1_used),
        .dec_rs2_addr(dec_rs2_addr), .dec_rs2_used(dec_rs2_used),
        .dec_rd_addr(dec_rd_addr), .dec_rd_used(dec_rd_used),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
        .ex_redirect(ex_redirect), .ex_excep(ex_excep),
        .trap_ack(trap_ack), .mem_busy(mem_busy),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .flush_fetch(flush_fetch), .flush_decode(flush_decode),
        .issue(issue), .busy_vec(busy_vec), .sb_underflow(sb_underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending-write counts per register plus flush/trap bookkeeping.
    int m_cnt [32];
    bit m_trap;
    int m_flush_left;
    bit m_last_v;
    int m_last_rd;
    bit m_uf;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        issue;
        logic [31:0] busy;
    } exp_t;

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_trap = 0; m_flush_left = 0; m_last_v = 0; m_last_rd = 0; m_uf = 0;
    endtask

    function automatic bit src_blocked(input logic used, input logic [4:0] a);
        if (!used || a == 0 || m_cnt[a] == 0) return 0;
        if (WB_BYPASS && wb_valid && wb_rd_addr == a && m_cnt[a] == 1) return 0;
        return 1;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        bit   full, hz;
        full = dec_rd_used && dec_rd_addr != 0 && m_cnt[dec_rd_addr] >= MAXC
               && !(WB_BYPASS && wb_valid && wb_rd_addr == dec_rd_addr);
        hz = src_blocked(dec_rs1_used, dec_rs1_addr) || src_blocked(dec_rs2_used, dec_rs2_addr) || full;
        e.flush = m_trap || m_flush_left > 0 || ex_redirect || ex_excep;
        e.stall = !e.flush && dec_valid && (hz || mem_busy);
        e.issue = dec_valid && !e.stall && !e.flush;
        e.busy  = '0;
        for (int i = 1; i < 32; i++) e.busy[i] = (m_cnt[i] > 0);
        return e;
    endfunction

    task automatic model_update();
        exp_t e;
        int   d [32];
        int   v;
        e = model_out();
        foreach (d[i]) d[i] = 0;
        if (wb_valid && wb_rd_addr != 0) begin
            if (m_cnt[wb_rd_addr] == 0) m_uf = 1;
            d[wb_rd_addr]--;
        end
        if (e.issue && dec_rd_used && dec_rd_addr != 0) d[dec_rd_addr]++;
        if ((ex_redirect || ex_excep) && m_last_v) d[m_last_rd]--;
        for (int i = 1; i < 32; i++) begin
            v = m_cnt[i] + d[i];
            m_cnt[i] = (v < 0) ? 0 : (v > MAXC) ? MAXC : v;
        end
        m_last_v  = e.issue && dec_rd_used && dec_rd_addr != 0;
        m_last_rd = int'(dec_rd_addr);
        if (m_trap) begin
            if (trap_ack) m_trap = 0;
        end else if (ex_excep) begin
            m_trap = 1; m_flush_left = 0;
        end else if (ex_redirect) begin
            m_flush_left = FLUSH_CYCLES;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs1_addr = 0; dec_rs1_used = 0; dec_rs2_addr = 0; dec_rs2_used = 0;
        dec_rd_addr = 0; dec_rd_used = 0; wb_valid = 0; wb_rd_addr = 0;
        ex_redirect = 0; ex_excep = 0; trap_ack = 0; mem_busy = 0;
    endtask

    task automatic sample();
        exp_t e;
        @(negedge clk);
        e = model_out();
        check("stall_fetch", stall_fetch, e.stall);
        check("stall_decode", stall_decode, e.stall);
        check("flush_fetch", flush_fetch, e.flush);
        check("flush_decode", flush_decode, e.flush);
        check("issue", issue, e.issue);
        check("busy_vec", busy_vec, e.busy);
        check("sb_underflow", sb_underflow, m_uf);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, {stall_fetch, stall_decode}, 0);
        check({tag, "_flush"}, {flush_fetch, flush_decode}, 0);
        check({tag, "_issue"}, issue, 0);
        check({tag, "_busy"}, busy_vec, 0);
        check({tag, "_uf"}, sb_underflow, 0);
    endtask

    typedef struct {
        logic        dv;
        logic [4:0]  rs1;
        logic        rs1u;
        logic [4:0]  rs2;
        logic        rs2u;
        logic [4:0]  rd;
        logic        rdu;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        mb;
        logic        e_stall;
        logic        e_issue;
        logic [31:0] e_busy;
    } vec_t;

    function automatic vec_t mk(input int dv, input int rs1, input int rs1u, input int rs2, input int rs2u,
                                input int rd, input int rdu, input int wbv, input int wbrd, input int mb,
                                input int st, input int is, input logic [31:0] busy);
        vec_t v;
        v.dv = dv[0]; v.rs1 = 5'(rs1); v.rs1u = rs1u[0]; v.rs2 = 5'(rs2); v.rs2u = rs2u[0];
        v.rd = 5'(rd); v.rdu = rdu[0]; v.wbv = wbv[0]; v.wbrd = 5'(wbrd); v.mb = mb[0];
        v.e_stall = st[0]; v.e_issue = is[0]; v.e_busy = busy;
        return v;
    endfunction

    vec_t tbl [19];

    initial begin
        //            dv rs1 u rs2 u rd u wb rd mb  st is busy
        tbl[0]  = mk(1, 0, 1, 0, 0, 5, 1, 0, 0, 0,  0, 1, 32'h00);  // write x5
        tbl[1]  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0,  1, 0, 32'h20);  // read x5: RAW
        tbl[2]  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0,  1, 0, 32'h20);
        tbl[3]  = mk(1, 5, 1, 0, 0, 6, 1, 1, 5, 0,  0, 1, 32'h20);  // wb x5 bypass
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h40);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0,  0, 0, 32'h40);
        tbl[6]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 32'h00);  // x7 write #1
        tbl[7]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 32'h80);
        tbl[8]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 32'h80);
        tbl[9]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 32'h80);  // 4th write: full
        tbl[10] = mk(1, 0, 0, 0, 0, 7, 1, 1, 7, 0,  0, 1, 32'h80);  // wb frees slot
        tbl[11] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 32'h80);
        tbl[12] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 32'h80);  // mem_busy
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 32'h80);
        tbl[14] = mk(1, 0, 0, 7, 1, 0, 0, 1, 7, 0,  1, 0, 32'h80);  // cnt 3: no bypass
        tbl[15] = mk(1, 0, 1, 0, 1, 0, 1, 1, 0, 0,  0, 1, 32'h80);  // x0 everywhere
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 32'h80);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 32'h80);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h00);

        idle();
        model_reset();
        reset = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1;
        advance();

        foreach (tbl[i]) begin
            idle();
            dec_valid = tbl[i].dv; dec_rs1_addr = tbl[i].rs1; dec_rs1_used = tbl[i].rs1u;
            dec_rs2_addr = tbl[i].rs2; dec_rs2_used = tbl[i].rs2u;
            dec_rd_addr = tbl[i].rd; dec_rd_used = tbl[i].rdu;
            wb_valid = tbl[i].wbv; wb_rd_addr = tbl[i].wbrd; mem_busy = tbl[i].mb;
            sample();
            check($sformatf("tbl%0d_stall", i), stall_decode, tbl[i].e_stall);
            check($sformatf("tbl%0d_issue", i), issue, tbl[i].e_issue);
            check($sformatf("tbl%0d_busy", i), busy_vec, tbl[i].e_busy);
            advance();
        end

        // Redirect squashes the x9 write issued the cycle before; flush spans 3 cycles.
        idle(); dec_valid = 1; dec_rd_addr = 9; dec_rd_used = 1;
        sample(); check("redir_issue_x9", issue, 1); advance();
        ex_redirect = 1; dec_rd_addr = 10;
        sample();
        check("redir_flush_t1", flush_fetch, 1); check("redir_stall_t1", stall_fetch, 0);
        check("redir_noissue", issue, 0); check("redir_busy9", busy_vec[9], 1);
        advance();
        ex_redirect = 0; dec_rd_used = 0; mem_busy = 1;
        sample();
        check("redir_flush_t2", flush_decode, 1); check("redir_stall_t2", stall_decode, 0);
        check("redir_undo_x9", busy_vec, 0);
        advance();
        sample(); check("redir_flush_t3", flush_fetch, 1); check("redir_stall_t3", stall_fetch, 0); advance();
        sample(); check("redir_flush_end", flush_fetch, 0); check("redir_stall_back", stall_decode, 1); advance();

        // Exception + redirect together: TRAP, held until trap_ack.
        idle(); ex_excep = 1; ex_redirect = 1;
        sample(); check("trap_flush_t0", flush_decode, 1); advance();
        for (int k = 1; k <= 4; k++) begin
            idle(); ex_redirect = (k == 2);
            sample(); check($sformatf("trap_hold_%0d", k), flush_fetch, 1); advance();
        end
        idle(); trap_ack = 1;
        sample(); check("trap_ack_cycle", flush_fetch, 1); advance();
        idle(); dec_valid = 1;
        sample(); check("trap_exit_flush", flush_decode, 0); check("trap_exit_issue", issue, 1); advance();
        idle(); trap_ack = 1;
        sample(); check("ack_in_run", flush_fetch, 0); advance();

        // Reload of the flush counter by a second redirect.
        idle(); ex_redirect = 1; sample(); advance();
        idle(); sample(); advance();
        idle(); ex_redirect = 1; sample(); advance();
        idle(); sample(); check("reload_hold_1", flush_fetch, 1); advance();
        idle(); sample(); check("reload_hold_2", flush_fetch, 1); advance();
        idle(); sample(); check("reload_end", flush_fetch, 0); advance();

        // Exception while flushing goes to TRAP and outlasts the flush window.
        idle(); ex_redirect = 1; sample(); advance();
        idle(); sample(); advance();
        idle(); ex_excep = 1; sample(); advance();
        idle(); sample(); check("excep_in_flush_1", flush_fetch, 1); advance();
        idle(); sample(); check("excep_in_flush_2", flush_fetch, 1); advance();
        idle(); trap_ack = 1; sample(); advance();
        idle(); sample(); check("excep_in_flush_exit", flush_fetch, 0); advance();

        // Underflow is sticky; x0 traffic never stalls or shows busy.
        idle(); wb_valid = 1; wb_rd_addr = 12;
        sample(); check("uf_before", sb_underflow, 0); advance();
        idle(); sample(); check("uf_set", sb_underflow, 1); advance();
        idle(); dec_valid = 1; dec_rs1_used = 1; dec_rd_used = 1; wb_valid = 1;
        sample();
        check("uf_sticky", sb_underflow, 1); check("x0_nostall", stall_decode, 0);
        check("x0_issue", issue, 1); check("x0_busy", busy_vec[0], 0);
        advance();

        // Asynchronous reset in the middle of a flush with live counters.
        idle(); dec_valid = 1; dec_rd_used = 1; dec_rd_addr = 3; sample(); advance();
        dec_rd_addr = 4; sample(); advance();
        idle(); ex_redirect = 1; sample(); advance();
        idle(); dec_valid = 1;
        sample();
        check("pre_reset_flush", flush_fetch, 1); check("pre_reset_busy", busy_vec, 32'h8);
        #1 reset = 0;
        #1 check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_held");
        idle(); dec_valid = 1; reset = 1;
        advance();
        sample(); check("post_reset_issue", issue, 1); advance();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            dec_valid    = ($urandom_range(0, 3) != 0);
            dec_rs1_addr = 5'($urandom_range(0, 3));
            dec_rs1_used = 1'($urandom_range(0, 1));
            dec_rs2_addr = 5'($urandom_range(0, 3));
            dec_rs2_used = 1'($urandom_range(0, 1));
            dec_rd_addr  = 5'($urandom_range(0, 3));
            dec_rd_used  = 1'($urandom_range(0, 1));
            wb_valid     = ($urandom_range(0, 2) == 0);
            wb_rd_addr   = 5'($urandom_range(0, 3));
            ex_redirect  = ($urandom_range(0, 19) == 0);
            ex_excep     = ($urandom_range(0, 59) == 0);
            trap_ack     = ($urandom_range(0, 5) == 0);
            mem_busy     = ($urandom_range(0, 7) == 0);
            sample();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
